// File: rtl/switch_allocator_pkg.sv
// rtl/switch_allocator_pkg.sv - shared router constants, port index and output-state types
package switch_allocator_pkg;

    localparam int NUM_PORTS = 5;
    localparam int PORT_W    = $clog2(NUM_PORTS);

    typedef logic [PORT_W-1:0] PORT_IDX_t;

    typedef enum logic {
        OUT_FREE   = 1'b0,
        OUT_LOCKED = 1'b1
    } OUT_STATE_t;

    // Port after p, wrapping at the last port
    function automatic PORT_IDX_t next_port(input PORT_IDX_t p);
        return (int'(p) == NUM_PORTS - 1) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// rtl/switch_allocator_if.sv - switch request/ack and crossbar control bundle
interface switch_allocator_if;
    import switch_allocator_pkg::*;

    logic      [NUM_PORTS-1:0] i_req;
    PORT_IDX_t [NUM_PORTS-1:0] i_dest;
    logic      [NUM_PORTS-1:0] i_packet_done;
    logic      [NUM_PORTS-1:0] o_ack;
    PORT_IDX_t [NUM_PORTS-1:0] o_xbar_sel;
    logic      [NUM_PORTS-1:0] o_out_valid;
    logic                      o_dest_err;

    // Input units / crossbar side
    modport master (
        output i_req, i_dest, i_packet_done,
        input  o_ack, o_xbar_sel, o_out_valid, o_dest_err
    );

    // Allocator side
    modport slave (
        input  i_req, i_dest, i_packet_done,
        output o_ack, o_xbar_sel, o_out_valid, o_dest_err
    );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// rtl/switch_allocator_rr_arbiter.sv - combinational round-robin arbiter starting at a pointer
module rr_arbiter #(
    parameter int N = 5,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] gnt_idx_o,
    output logic         any_o
);

    // Scan from ptr_i upward, wrapping, and take the first requester found
    always_comb begin : scan
        int          idx;
        logic [W-1:0] idx_w;
        logic        found;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = W'(idx);
            if (!found && req_i[idx_w]) begin
                found        = 1'b1;
                gnt_o[idx_w] = 1'b1;
                gnt_idx_o    = idx_w;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - per-output round-robin wormhole switch allocator
module switch_allocator
    import switch_allocator_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    switch_allocator_if.slave  bus
);

    OUT_STATE_t state_q [NUM_PORTS];
    OUT_STATE_t state_d [NUM_PORTS];
    PORT_IDX_t  owner_q [NUM_PORTS];
    PORT_IDX_t  owner_d [NUM_PORTS];
    PORT_IDX_t  ptr_q   [NUM_PORTS];
    PORT_IDX_t  ptr_d   [NUM_PORTS];

    logic [NUM_PORTS-1:0] owns_q, owns_d;
    logic [NUM_PORTS-1:0] ack_q, ack_d;
    logic                 err_q, err_d;

    logic [NUM_PORTS-1:0] dest_ok;
    logic [NUM_PORTS-1:0] cand    [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt     [NUM_PORTS];
    PORT_IDX_t            gnt_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt_any;

    // Per-output candidate vectors: inputs that own a port or were just acked are masked
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            dest_ok[i] = int'(bus.i_dest[i]) < NUM_PORTS;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand[o][i] = bus.i_req[i] && dest_ok[i] &&
                             (bus.i_dest[i] == PORT_IDX_t'(o)) &&
                             !owns_q[i] && !ack_q[i];
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arbiter #(
            .N (NUM_PORTS),
            .W (PORT_W)
        ) u_arb (
            .req_i     (cand[o]),
            .ptr_i     (ptr_q[o]),
            .gnt_o     (gnt[o]),
            .gnt_idx_o (gnt_idx[o]),
            .any_o     (gnt_any[o])
        );
    end

    // Output FSMs: lock on a grant, free on the owner's tail pulse (release beats a new grant)
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        owns_d  = owns_q;
        ack_d   = '0;
        err_d   = err_q | (|(bus.i_req & ~dest_ok));
        for (int o = 0; o < NUM_PORTS; o++) begin
            case (state_q[o])
                OUT_FREE: begin
                    if (gnt_any[o]) begin
                        state_d[o] = OUT_LOCKED;
                        owner_d[o] = gnt_idx[o];
                        ack_d      = ack_d | gnt[o];
                        owns_d     = owns_d | gnt[o];
                    end
                end
                OUT_LOCKED: begin
                    if (bus.i_packet_done[owner_q[o]]) begin
                        state_d[o]         = OUT_FREE;
                        ptr_d[o]           = next_port(owner_q[o]);
                        owns_d[owner_q[o]] = 1'b0;
                    end
                end
                default: state_d[o] = OUT_FREE;
            endcase
        end
    end

    // State registers; asynchronous reset drops every lock at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= OUT_FREE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
            owns_q <= '0;
            ack_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            owns_q  <= owns_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Drive crossbar selects, valids, acks and the sticky error flag
    always_comb begin
        bus.o_ack      = ack_q;
        bus.o_dest_err = err_q;
        for (int o = 0; o < NUM_PORTS; o++) begin
            bus.o_xbar_sel[o]  = owner_q[o];
            bus.o_out_valid[o] = (state_q[o] == OUT_LOCKED);
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - self-checking bench for switch_allocator
module tb_switch_allocator;
    import switch_allocator_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    switch_allocator_if bus();

    switch_allocator dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: which outputs are held, by whom, and where each search starts
    bit                 m_locked [NUM_PORTS];
    int                 m_owner  [NUM_PORTS];
    int                 m_ptr    [NUM_PORTS];
    bit [NUM_PORTS-1:0] m_ack;
    bit                 m_err;

    function automatic void model_reset();
        for (int o = 0; o < NUM_PORTS; o++) begin
            m_locked[o] = 0;
            m_owner[o]  = 0;
            m_ptr[o]    = 0;
        end
        m_ack = '0;
        m_err = 0;
    endfunction

    function automatic void model_step();
        bit                 nl [NUM_PORTS];
        int                 no [NUM_PORTS];
        int                 np [NUM_PORTS];
        bit                 busy [NUM_PORTS];
        bit [NUM_PORTS-1:0] nack;
        bit                 found;
        int                 i;
        nack = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            nl[o] = m_locked[o]; no[o] = m_owner[o]; np[o] = m_ptr[o]; busy[o] = 0;
        end
        for (int o = 0; o < NUM_PORTS; o++)
            if (m_locked[o]) busy[m_owner[o]] = 1;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (m_locked[o]) begin
                if (bus.i_packet_done[m_owner[o]]) begin
                    nl[o] = 0;
                    np[o] = (m_owner[o] + 1) % NUM_PORTS;
                end
            end else begin
                found = 0;
                for (int k = 0; k < NUM_PORTS; k++) begin
                    i = (m_ptr[o] + k) % NUM_PORTS;
                    if (!found && bus.i_req[i] && int'(bus.i_dest[i]) == o && !busy[i] && !m_ack[i]) begin
                        found   = 1;
                        nl[o]   = 1;
                        no[o]   = i;
                        nack[i] = 1;
                    end
                end
            end
        end
        for (int n = 0; n < NUM_PORTS; n++)
            if (bus.i_req[n] && int'(bus.i_dest[n]) >= NUM_PORTS) m_err = 1;
        for (int o = 0; o < NUM_PORTS; o++) begin
            m_locked[o] = nl[o]; m_owner[o] = no[o]; m_ptr[o] = np[o];
        end
        m_ack = nack;
    endfunction

    function automatic bit [NUM_PORTS-1:0] model_valid();
        bit [NUM_PORTS-1:0] v;
        for (int o = 0; o < NUM_PORTS; o++) v[o] = m_locked[o];
        return v;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_req         = '0;
        bus.i_packet_done = '0;
        for (int n = 0; n < NUM_PORTS; n++) bus.i_dest[n] = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        vectors++; if (bus.o_ack !== 5'b00000) begin miscompares++; $display("FAIL reset_ack got %b want 00000", bus.o_ack); end
        vectors++; if (bus.o_out_valid !== 5'b00000) begin miscompares++; $display("FAIL reset_valid got %b want 00000", bus.o_out_valid); end
        vectors++; if (bus.o_xbar_sel !== 15'd0) begin miscompares++; $display("FAIL reset_sel got %h want 0", bus.o_xbar_sel); end
        vectors++; if (bus.o_dest_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", bus.o_dest_err); end
        reset_n = 1'b1;
        tick();
        vectors++; if (bus.o_out_valid !== 5'b00000) begin miscompares++; $display("FAIL idle_valid got %b want 00000", bus.o_out_valid); end
    endtask

    task automatic test_single();
        bus.i_req[0] = 1'b1; bus.i_dest[0] = 3'd2;
        tick();
        vectors++; if (bus.o_ack !== 5'b00001) begin miscompares++; $display("FAIL single_ack got %b want 00001", bus.o_ack); end
        vectors++; if (bus.o_out_valid !== 5'b00100) begin miscompares++; $display("FAIL single_valid got %b want 00100", bus.o_out_valid); end
        vectors++; if (bus.o_xbar_sel[2] !== 3'd0) begin miscompares++; $display("FAIL single_sel got %0d want 0", bus.o_xbar_sel[2]); end
        bus.i_req[0] = 1'b0;
        repeat (3) tick();
        vectors++; if (bus.o_ack !== 5'b00000 || bus.o_out_valid !== 5'b00100) begin miscompares++; $display("FAIL single_hold got ack %b valid %b want 00000 00100", bus.o_ack, bus.o_out_valid); end
        bus.i_packet_done[0] = 1'b1;
        tick();
        bus.i_packet_done[0] = 1'b0;
        vectors++; if (bus.o_out_valid !== 5'b00000) begin miscompares++; $display("FAIL single_release got %b want 00000", bus.o_out_valid); end
        tick();
    endtask

    task automatic test_contention();
        bus.i_req[1] = 1'b1; bus.i_req[3] = 1'b1; bus.i_req[4] = 1'b1;
        tick();
        vectors++; if (bus.o_ack !== 5'b00010 || bus.o_xbar_sel[0] !== 3'd1) begin miscompares++; $display("FAIL cont_first got ack %b sel %0d want 00010 1", bus.o_ack, bus.o_xbar_sel[0]); end
        bus.i_req[1] = 1'b0;
        tick();
        vectors++; if (bus.o_ack !== 5'b00000) begin miscompares++; $display("FAIL cont_pulse got %b want 00000", bus.o_ack); end
        bus.i_packet_done[1] = 1'b1;
        tick();
        bus.i_packet_done[1] = 1'b0;
        vectors++; if (bus.o_ack !== 5'b00000 || bus.o_out_valid[0] !== 1'b0) begin miscompares++; $display("FAIL cont_gap got ack %b valid %b want 00000 0", bus.o_ack, bus.o_out_valid[0]); end
        tick();
        vectors++; if (bus.o_ack !== 5'b01000 || bus.o_xbar_sel[0] !== 3'd3) begin miscompares++; $display("FAIL cont_second got ack %b sel %0d want 01000 3", bus.o_ack, bus.o_xbar_sel[0]); end
        bus.i_req[3] = 1'b0; bus.i_packet_done[3] = 1'b1;
        tick();
        bus.i_packet_done[3] = 1'b0;
        tick();
        vectors++; if (bus.o_ack !== 5'b10000 || bus.o_xbar_sel[0] !== 3'd4) begin miscompares++; $display("FAIL cont_third got ack %b sel %0d want 10000 4", bus.o_ack, bus.o_xbar_sel[0]); end
        bus.i_req[4] = 1'b0; bus.i_packet_done[4] = 1'b1;
        tick();
        bus.i_packet_done[4] = 1'b0;
        bus.i_req[4] = 1'b1; bus.i_req[1] = 1'b1;
        tick();
        vectors++; if (bus.o_ack !== 5'b00010 || bus.o_xbar_sel[0] !== 3'd1) begin miscompares++; $display("FAIL cont_wrap got ack %b sel %0d want 00010 1", bus.o_ack, bus.o_xbar_sel[0]); end
        clear_inputs();
        bus.i_packet_done[1] = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_parallel();
        bus.i_req = 5'b11111;
        for (int n = 0; n < NUM_PORTS; n++) bus.i_dest[n] = PORT_IDX_t'(NUM_PORTS - 1 - n);
        tick();
        vectors++; if (bus.o_ack !== 5'b11111 || bus.o_out_valid !== 5'b11111) begin miscompares++; $display("FAIL par_ack got ack %b valid %b want 11111 11111", bus.o_ack, bus.o_out_valid); end
        for (int o = 0; o < NUM_PORTS; o++) begin
            vectors++; if (int'(bus.o_xbar_sel[o]) != NUM_PORTS - 1 - o) begin miscompares++; $display("FAIL par_sel%0d got %0d want %0d", o, bus.o_xbar_sel[o], NUM_PORTS - 1 - o); end
        end
        clear_inputs();
        bus.i_packet_done = 5'b11111;
        tick();
        clear_inputs();
        vectors++; if (bus.o_out_valid !== 5'b00000) begin miscompares++; $display("FAIL par_release got %b want 00000", bus.o_out_valid); end
        tick();
    endtask

    task automatic test_collision();
        bus.i_req[2] = 1'b1; bus.i_dest[2] = 3'd1;
        tick();
        bus.i_req[2] = 1'b0;
        tick();
        bus.i_packet_done[2] = 1'b1;
        bus.i_req[3] = 1'b1; bus.i_dest[3] = 3'd1;
        tick();
        bus.i_packet_done[2] = 1'b0;
        vectors++; if (bus.o_ack !== 5'b00000 || bus.o_out_valid[1] !== 1'b0) begin miscompares++; $display("FAIL coll_release got ack %b valid %b want 00000 0", bus.o_ack, bus.o_out_valid[1]); end
        tick();
        vectors++; if (bus.o_ack !== 5'b01000 || bus.o_xbar_sel[1] !== 3'd3) begin miscompares++; $display("FAIL coll_grant got ack %b sel %0d want 01000 3", bus.o_ack, bus.o_xbar_sel[1]); end
        clear_inputs();
        bus.i_packet_done[3] = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_masking();
        bus.i_req[0] = 1'b1; bus.i_dest[0] = 3'd1;
        tick();
        vectors++; if (bus.o_ack !== 5'b00001) begin miscompares++; $display("FAIL mask_first got %b want 00001", bus.o_ack); end
        tick();
        vectors++; if (bus.o_ack !== 5'b00000) begin miscompares++; $display("FAIL mask_no_reack got %b want 00000", bus.o_ack); end
        bus.i_dest[0] = 3'd3;
        repeat (3) tick();
        vectors++; if (bus.o_ack !== 5'b00000 || bus.o_out_valid !== 5'b00010) begin miscompares++; $display("FAIL mask_hold got ack %b valid %b want 00000 00010", bus.o_ack, bus.o_out_valid); end
        bus.i_packet_done[0] = 1'b1;
        tick();
        bus.i_packet_done[0] = 1'b0;
        vectors++; if (bus.o_ack !== 5'b00000 || bus.o_out_valid !== 5'b00000) begin miscompares++; $display("FAIL mask_release got ack %b valid %b want 00000 00000", bus.o_ack, bus.o_out_valid); end
        tick();
        vectors++; if (bus.o_ack !== 5'b00001 || bus.o_out_valid !== 5'b01000 || bus.o_xbar_sel[3] !== 3'd0) begin miscompares++; $display("FAIL mask_regrant got ack %b valid %b sel %0d want 00001 01000 0", bus.o_ack, bus.o_out_valid, bus.o_xbar_sel[3]); end
        clear_inputs();
        bus.i_packet_done[0] = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_dest_err();
        bus.i_req[2] = 1'b1; bus.i_dest[2] = 3'd7;
        tick();
        vectors++; if (bus.o_dest_err !== 1'b1 || bus.o_ack !== 5'b00000 || bus.o_out_valid !== 5'b00000) begin miscompares++; $display("FAIL err_set got err %b ack %b valid %b want 1 00000 00000", bus.o_dest_err, bus.o_ack, bus.o_out_valid); end
        clear_inputs();
        repeat (2) tick();
        vectors++; if (bus.o_dest_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b want 1", bus.o_dest_err); end
    endtask

    task automatic test_async_reset();
        bus.i_req = 5'b00011; bus.i_dest[0] = 3'd0; bus.i_dest[1] = 3'd1;
        tick();
        vectors++; if (bus.o_out_valid !== 5'b00011) begin miscompares++; $display("FAIL ares_locked got %b want 00011", bus.o_out_valid); end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (bus.o_out_valid !== 5'b00000 || bus.o_ack !== 5'b00000 || bus.o_dest_err !== 1'b0) begin miscompares++; $display("FAIL ares_drop got valid %b ack %b err %b want 00000 00000 0", bus.o_out_valid, bus.o_ack, bus.o_dest_err); end
        clear_inputs();
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.i_req = 5'b01010; bus.i_dest[1] = 3'd2; bus.i_dest[3] = 3'd2;
        tick();
        vectors++; if (bus.o_ack !== 5'b00010 || bus.o_xbar_sel[2] !== 3'd1) begin miscompares++; $display("FAIL ares_ptr got ack %b sel %0d want 00010 1", bus.o_ack, bus.o_xbar_sel[2]); end
        clear_inputs();
        bus.i_packet_done[1] = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        bit [NUM_PORTS-1:0] ev;
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < NUM_PORTS; n++) begin
                bus.i_req[n]         = ($urandom_range(0, 2) != 0);
                bus.i_dest[n]        = ($urandom_range(0, 29) == 0) ? PORT_IDX_t'($urandom_range(5, 7))
                                                                     : PORT_IDX_t'($urandom_range(0, 4));
                bus.i_packet_done[n] = ($urandom_range(0, 3) == 0);
            end
            tick();
            ev = model_valid();
            vectors++; if (bus.o_ack !== m_ack) begin miscompares++; $display("FAIL rand_ack cyc %0d got %b want %b", c, bus.o_ack, m_ack); end
            vectors++; if (bus.o_out_valid !== ev) begin miscompares++; $display("FAIL rand_valid cyc %0d got %b want %b", c, bus.o_out_valid, ev); end
            vectors++; if (bus.o_dest_err !== m_err) begin miscompares++; $display("FAIL rand_err cyc %0d got %b want %b", c, bus.o_dest_err, m_err); end
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (m_locked[o]) begin
                    vectors++; if (int'(bus.o_xbar_sel[o]) != m_owner[o]) begin miscompares++; $display("FAIL rand_sel cyc %0d out %0d got %0d want %0d", c, o, bus.o_xbar_sel[o], m_owner[o]); end
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_parallel();
        test_collision();
        test_masking();
        test_dest_err();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
